// File: rtl/bpi_upgrade_rx.sv
// Upgrade-packet receiver: parses framed upgrade/reconfig packets, packs the payload
// into a 128x16 page buffer, hands each page to the exchange stage and relays its result.
module bpi_upgrade_rx #(
  parameter int unsigned FRAME_LEN      = 261,
  parameter logic [23:0] RESULT_TIMEOUT = 24'hFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_en,
  output logic        config_reset,
  output logic        update_flag,
  output logic        reconfig_flag,
  output logic [15:0] pack_cnt,
  output logic [15:0] pack_num,
  output logic        wr_ram_end,
  input  logic        wr_ram_ack,
  input  logic        wr_ram_en,
  input  logic [6:0]  wr_ram_raddr,
  output logic [15:0] wr_ram_rdata,
  input  logic [7:0]  con_dout,
  input  logic        con_dout_en,
  output logic [7:0]  ack_dout,
  output logic        ack_en,
  output logic [15:0] drop_cnt
);

  localparam logic [8:0] FRAME_LEN_C = FRAME_LEN[8:0];

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_HANDOFF = 3'd4,
    ST_WAIT    = 3'd5,
    ST_REPORT  = 3'd6
  } state_t;

  state_t      state_r;
  logic [8:0]  byte_cnt_r;
  logic [7:0]  hdr_type_r;
  logic [15:0] hdr_num_r;
  logic [15:0] hdr_cnt_r;
  logic [7:0]  hi_byte_r;
  logic [15:0] exp_cnt_r;
  logic [23:0] timer_r;
  logic        din_en_d_r;
  logic        dropping_r;
  logic        pend_e4_r;
  logic        config_reset_r;
  logic        update_flag_r;
  logic        reconfig_flag_r;
  logic [15:0] pack_cnt_r;
  logic [15:0] pack_num_r;
  logic        wr_ram_end_r;
  logic [15:0] wr_ram_rdata_r;
  logic [7:0]  ack_dout_r;
  logic        ack_en_r;
  logic [15:0] drop_cnt_r;

  logic [15:0] mem_r [0:127];

  logic        busy_s;
  logic        din_rise_s;
  logic [8:0]  pay_idx_s;
  logic        mem_we_s;
  logic [6:0]  mem_addr_s;
  logic [15:0] mem_wdata_s;
  logic        chk_fail_s;
  logic [7:0]  chk_code_s;
  logic [8:0]  byte_cnt_inc_s;

  assign config_reset  = config_reset_r;
  assign update_flag   = update_flag_r;
  assign reconfig_flag = reconfig_flag_r;
  assign pack_cnt      = pack_cnt_r;
  assign pack_num      = pack_num_r;
  assign wr_ram_end    = wr_ram_end_r;
  assign wr_ram_rdata  = wr_ram_rdata_r;
  assign ack_dout      = ack_dout_r;
  assign ack_en        = ack_en_r;
  assign drop_cnt      = drop_cnt_r;

  // Busy/edge detection and payload write decode; the odd byte of each pair commits the word.
  always_comb begin
    busy_s         = (state_r == ST_CHECK) || (state_r == ST_HANDOFF) ||
                     (state_r == ST_WAIT)  || (state_r == ST_REPORT);
    din_rise_s     = din_en & ~din_en_d_r;
    byte_cnt_inc_s = (byte_cnt_r == 9'h1FF) ? byte_cnt_r : (byte_cnt_r + 9'd1);
    pay_idx_s      = byte_cnt_r - 9'd5;
    mem_addr_s     = pay_idx_s[7:1];
    mem_wdata_s    = {hi_byte_r, din};
    if ((state_r == ST_PAYLOAD) && din_en && (byte_cnt_r < FRAME_LEN_C) && pay_idx_s[0]) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Frame validation, first failing rule wins.
  always_comb begin
    chk_fail_s = 1'b1;
    chk_code_s = 8'h00;
    if (byte_cnt_r != FRAME_LEN_C) begin
      chk_code_s = 8'hE1;
    end else if ((hdr_type_r != 8'h01) && (hdr_type_r != 8'h02)) begin
      chk_code_s = 8'hE2;
    end else if ((hdr_cnt_r == 16'd0) || (hdr_cnt_r > hdr_num_r) ||
                 ((hdr_cnt_r != exp_cnt_r) && (hdr_cnt_r != 16'd1))) begin
      chk_code_s = 8'hE3;
    end else begin
      chk_fail_s = 1'b0;
    end
  end

  // Page buffer write port (contents need no reset).
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

  // Page buffer registered read port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ram_rdata_r <= 16'h0000;
    end else if (wr_ram_en) begin
      wr_ram_rdata_r <= mem_r[wr_ram_raddr];
    end
  end

  // Receive/handoff/report state machine with registered outputs and busy-drop tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= ST_IDLE;
      byte_cnt_r      <= 9'd0;
      hdr_type_r      <= 8'h00;
      hdr_num_r       <= 16'h0000;
      hdr_cnt_r       <= 16'h0000;
      hi_byte_r       <= 8'h00;
      exp_cnt_r       <= 16'd1;
      timer_r         <= 24'd0;
      din_en_d_r      <= 1'b0;
      dropping_r      <= 1'b0;
      pend_e4_r       <= 1'b0;
      config_reset_r  <= 1'b0;
      update_flag_r   <= 1'b0;
      reconfig_flag_r <= 1'b0;
      pack_cnt_r      <= 16'h0000;
      pack_num_r      <= 16'h0000;
      wr_ram_end_r    <= 1'b0;
      ack_dout_r      <= 8'h00;
      ack_en_r        <= 1'b0;
      drop_cnt_r      <= 16'h0000;
    end else begin
      din_en_d_r     <= din_en;
      config_reset_r <= 1'b0;
      ack_en_r       <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          // Queued busy-drop status waits until any other status pulse has cleared.
          if (pend_e4_r && !ack_en_r) begin
            ack_en_r   <= 1'b1;
            ack_dout_r <= 8'hE4;
            pend_e4_r  <= 1'b0;
          end
          if (din_en && !dropping_r) begin
            hdr_type_r <= din;
            byte_cnt_r <= 9'd1;
            state_r    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (din_en) begin
            case (byte_cnt_r)
              9'd1:    hdr_num_r[15:8] <= din;
              9'd2:    hdr_num_r[7:0]  <= din;
              9'd3:    hdr_cnt_r[15:8] <= din;
              9'd4:    hdr_cnt_r[7:0]  <= din;
              default: hdr_num_r       <= hdr_num_r;
            endcase
            byte_cnt_r <= byte_cnt_inc_s;
            if (byte_cnt_r == 9'd4) begin
              state_r <= ST_PAYLOAD;
            end
          end else begin
            state_r <= ST_CHECK;
          end
        end
        ST_PAYLOAD: begin
          if (din_en) begin
            byte_cnt_r <= byte_cnt_inc_s;
            if (!pay_idx_s[0]) begin
              hi_byte_r <= din;
            end
          end else begin
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (chk_fail_s) begin
            ack_en_r   <= 1'b1;
            ack_dout_r <= chk_code_s;
            state_r    <= ST_IDLE;
          end else begin
            pack_cnt_r   <= hdr_cnt_r;
            pack_num_r   <= hdr_num_r;
            exp_cnt_r    <= hdr_cnt_r + 16'd1;
            wr_ram_end_r <= 1'b1;
            state_r      <= ST_HANDOFF;
            if (hdr_cnt_r == 16'd1) begin
              update_flag_r   <= (hdr_type_r == 8'h01);
              reconfig_flag_r <= (hdr_type_r == 8'h02);
              config_reset_r  <= 1'b1;
            end
          end
        end
        ST_HANDOFF: begin
          if (wr_ram_ack) begin
            wr_ram_end_r <= 1'b0;
            timer_r      <= 24'd0;
            state_r      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (con_dout_en) begin
            ack_en_r   <= 1'b1;
            ack_dout_r <= con_dout;
            state_r    <= ST_REPORT;
            if ((con_dout == 8'hFF) ||
                ((con_dout == 8'h00) && (pack_cnt_r == pack_num_r))) begin
              exp_cnt_r <= 16'd1;
            end
          end else if (timer_r == (RESULT_TIMEOUT - 24'd1)) begin
            ack_en_r   <= 1'b1;
            ack_dout_r <= 8'hE5;
            exp_cnt_r  <= 16'd1;
            state_r    <= ST_REPORT;
          end else begin
            timer_r <= timer_r + 24'd1;
          end
        end
        ST_REPORT: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      // Placed after the state case so a drop ending in IDLE re-queues its own status.
      if (dropping_r) begin
        if (!din_en) begin
          dropping_r <= 1'b0;
          pend_e4_r  <= 1'b1;
          if (drop_cnt_r != 16'hFFFF) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
          end
        end
      end else if (busy_s && din_rise_s) begin
        dropping_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bpi_upgrade_rx.sv
// Directed bench for bpi_upgrade_rx: a frame-level model predicts status codes and
// handoff headers, a per-cycle compare process checks them, plus literal pins.
module tb_bpi_upgrade_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_en = 1'b0;
  logic        config_reset, update_flag, reconfig_flag;
  logic [15:0] pack_cnt, pack_num;
  logic        wr_ram_end;
  logic        wr_ram_ack = 1'b0;
  logic        wr_ram_en = 1'b0;
  logic [6:0]  wr_ram_raddr = 7'd0;
  logic [15:0] wr_ram_rdata;
  logic [7:0]  con_dout = 8'h00;
  logic        con_dout_en = 1'b0;
  logic [7:0]  ack_dout;
  logic        ack_en;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  bpi_upgrade_rx #(.FRAME_LEN(261), .RESULT_TIMEOUT(24'd100)) dut (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en),
    .config_reset(config_reset), .update_flag(update_flag), .reconfig_flag(reconfig_flag),
    .pack_cnt(pack_cnt), .pack_num(pack_num), .wr_ram_end(wr_ram_end),
    .wr_ram_ack(wr_ram_ack), .wr_ram_en(wr_ram_en), .wr_ram_raddr(wr_ram_raddr),
    .wr_ram_rdata(wr_ram_rdata), .con_dout(con_dout), .con_dout_en(con_dout_en),
    .ack_dout(ack_dout), .ack_en(ack_en), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level model state
  logic [7:0]  exp_q[$];
  logic [15:0] m_exp = 16'd1;
  logic        m_upd = 1'b0, m_rec = 1'b0;
  logic        m_hand_pend = 1'b0;
  logic [15:0] m_hand_cnt = 16'd0, m_hand_num = 16'd0;
  logic [15:0] m_cur_cnt = 16'd0, m_cur_num = 16'd0;
  logic        m_pend_e4 = 1'b0;
  logic        prev_end = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare process: every status pulse and every handoff against the model.
  always @(negedge clk) begin
    if (rst) begin
      if (ack_en) begin
        if (exp_q.size() == 0) check("unexpected_ack", {56'd0, ack_dout}, 64'h100);
        else check("ack_dout", {56'd0, ack_dout}, {56'd0, exp_q.pop_front()});
      end
      if (wr_ram_end && !prev_end) begin
        if (m_hand_pend) begin
          check("handoff_hdr", {32'd0, pack_cnt, pack_num}, {32'd0, m_hand_cnt, m_hand_num});
          check("handoff_flags", {61'd0, update_flag, reconfig_flag, config_reset},
                {61'd0, m_upd, m_rec, (m_hand_cnt == 16'd1)});
          m_hand_pend = 1'b0;
        end else begin
          check("unexpected_handoff", {63'd0, wr_ram_end}, 64'd0);
        end
      end else if (config_reset) begin
        check("stray_config_reset", {63'd0, config_reset}, 64'd0);
      end
    end
    prev_end = wr_ram_end;
  end

  function automatic logic [7:0] frame_byte(input logic [7:0] typ, input logic [15:0] num,
                                            input logic [15:0] cnt, input int i, input logic [7:0] seed);
    logic [7:0] b;
    case (i)
      0: b = typ;
      1: b = num[15:8];
      2: b = num[7:0];
      3: b = cnt[15:8];
      4: b = cnt[7:0];
      default: b = 8'(i - 5) + seed;
    endcase
    return b;
  endfunction

  task automatic model_frame(input logic [7:0] typ, input logic [15:0] num,
                             input logic [15:0] cnt, input int len);
    logic [7:0] code;
    code = 8'h00;
    if (len != 261) code = 8'hE1;
    else if (typ != 8'h01 && typ != 8'h02) code = 8'hE2;
    else if (cnt == 16'd0 || cnt > num || (cnt != m_exp && cnt != 16'd1)) code = 8'hE3;
    if (code != 8'h00) begin
      exp_q.push_back(code);
    end else begin
      m_hand_pend = 1'b1;
      m_hand_cnt = cnt;
      m_hand_num = num;
      m_cur_cnt = cnt;
      m_cur_num = num;
      if (cnt == 16'd1) begin
        m_upd = (typ == 8'h01);
        m_rec = (typ == 8'h02);
      end
      m_exp = cnt + 16'd1;
    end
  endtask

  task automatic model_status(input logic [7:0] code);
    exp_q.push_back(code);
    if (code == 8'hFF || code == 8'hE5 || (code == 8'h00 && m_cur_cnt == m_cur_num)) m_exp = 16'd1;
    if (m_pend_e4) begin
      exp_q.push_back(8'hE4);
      m_pend_e4 = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] typ, input logic [15:0] num, input logic [15:0] cnt,
                      input int len, input logic [7:0] seed);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      din_en = 1'b1;
      din = frame_byte(typ, num, cnt, i, seed);
    end
    @(posedge clk); #1;
    din_en = 1'b0;
    din = 8'h00;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!wr_ram_end && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("handoff_seen", {63'd0, wr_ram_end}, 64'd1);
  endtask

  task automatic give_ack();
    @(posedge clk); #1;
    wr_ram_ack = 1'b1;
    @(posedge clk); #1;
    wr_ram_ack = 1'b0;
    @(negedge clk);
    check("end_low_after_ack", {63'd0, wr_ram_end}, 64'd0);
  endtask

  task automatic give_result(input logic [7:0] code);
    model_status(code);
    @(posedge clk); #1;
    con_dout = code;
    con_dout_en = 1'b1;
    @(posedge clk); #1;
    con_dout_en = 1'b0;
  endtask

  task automatic wait_q(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("status_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rd(input logic [6:0] addr, output logic [15:0] data);
    @(posedge clk); #1;
    wr_ram_en = 1'b1;
    wr_ram_raddr = addr;
    @(posedge clk); #1;
    wr_ram_en = 1'b0;
    @(negedge clk);
    data = wr_ram_rdata;
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctl"}, {config_reset, update_flag, reconfig_flag, wr_ram_end, ack_en, ack_dout,
                           pack_cnt, pack_num}, 64'd0);
    check({name, "_data"}, {32'd0, wr_ram_rdata, drop_cnt}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int n;

    // Reset state
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Valid type 0x01 frame, pack 1 of 2, payload 0x00..0xFF
    model_frame(8'h01, 16'd2, 16'd1, 261);
    send(8'h01, 16'd2, 16'd1, 261, 8'h00);
    wait_end(10);
    check("A_config_reset", {63'd0, config_reset}, 64'd1);
    check("A_update_flag", {63'd0, update_flag}, 64'd1);
    rd(7'd0, d);   check("mem0", {48'd0, d}, 64'h0001);
    rd(7'd127, d); check("mem127", {48'd0, d}, 64'hFEFF);
    rd(7'd5, d);   check("mem5_before", {48'd0, d}, 64'h0A0B);
    give_ack();

    // Frame arriving while waiting for the result is dropped and reported after it
    m_pend_e4 = 1'b1;
    send(8'h01, 16'd2, 16'd1, 20, 8'h55);
    repeat (2) @(negedge clk);
    check("drop_cnt_one", {48'd0, drop_cnt}, 64'd1);
    give_result(8'h00);
    wait_q(20);
    rd(7'd5, d);   check("mem5_after", {48'd0, d}, 64'h0A0B);

    // Short frame, bad type, out-of-sequence pack
    model_frame(8'h01, 16'd2, 16'd2, 260);
    send(8'h01, 16'd2, 16'd2, 260, 8'h10);
    wait_q(20);
    model_frame(8'h07, 16'd2, 16'd2, 261);
    send(8'h07, 16'd2, 16'd2, 261, 8'h10);
    wait_q(20);
    model_frame(8'h01, 16'd3, 16'd3, 261);
    send(8'h01, 16'd3, 16'd3, 261, 8'h10);
    wait_q(20);

    // Page 2 accepted, verify fails, then page 2 again is out of sequence
    model_frame(8'h01, 16'd2, 16'd2, 261);
    send(8'h01, 16'd2, 16'd2, 261, 8'h20);
    wait_end(10);
    rd(7'd0, d);   check("mem0_page2", {48'd0, d}, 64'h2021);
    give_ack();
    give_result(8'hFF);
    wait_q(20);
    model_frame(8'h01, 16'd2, 16'd2, 261);
    send(8'h01, 16'd2, 16'd2, 261, 8'h20);
    wait_q(20);

    // Reset in the middle of the payload
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      din_en = 1'b1;
      din = frame_byte(8'h02, 16'd1, 16'd1, i, 8'h30);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    din_en = 1'b0;
    exp_q.delete();
    m_exp = 16'd1; m_upd = 1'b0; m_rec = 1'b0; m_hand_pend = 1'b0; m_pend_e4 = 1'b0;
    @(negedge clk);
    check_zero("midframe_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_frame(8'h02, 16'd1, 16'd1, 261);
    send(8'h02, 16'd1, 16'd1, 261, 8'h40);
    wait_end(10);
    check("reconfig_flag", {62'd0, update_flag, reconfig_flag}, 64'd1);
    give_ack();
    give_result(8'h00);
    wait_q(20);

    // Result timeout after handoff
    model_frame(8'h02, 16'd1, 16'd1, 261);
    send(8'h02, 16'd1, 16'd1, 261, 8'h50);
    wait_end(10);
    model_status(8'hE5);
    @(posedge clk); #1;
    wr_ram_ack = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    wr_ram_ack = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_en && n < 300);
    check("timeout_latency", 64'(n), 64'd101);
    wait_q(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpi_upgrade_rx.md
# bpi_upgrade_rx

Upgrade-packet receiver sitting directly upstream of the BPI data-exchange stage. Parses framed upgrade/reconfig packets from the control byte stream and packs the 256-byte payload into a 128×16 page buffer. Hands each page to the exchange stage over the `wr_ram_end` / `wr_ram_ack` handshake and serves its buffer read port. Relays the per-page programming result back to the control path as a status byte.

## Interface
- `FRAME_LEN`, 261: exact frame length in bytes (5 header + 256 payload).
- `RESULT_TIMEOUT`, 24'hFF_FFFF: cycles allowed between handoff and `con_dout_en`.
- `clk`  in  1  single system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `din`  in  8  control stream byte.
- `din_en`  in  1  byte valid; high for the whole frame, low between frames.
- `config_reset`  out  1  one-cycle pulse at handoff of a page with `pack_cnt`==1.
- `update_flag`  out  1  level; session targets the update region (type 0x01).
- `reconfig_flag`  out  1  level; session targets the reconfig region (type 0x02).
- `pack_cnt`  out  16  index of the page currently handed off.
- `pack_num`  out  16  total pages in the session.
- `wr_ram_end`  out  1  page buffer full, held until acknowledged.
- `wr_ram_ack`  in  1  one-cycle acknowledge from the exchange stage.
- `wr_ram_en`  in  1  buffer read enable.
- `wr_ram_raddr`  in  7  buffer read address.
- `wr_ram_rdata`  out  16  buffer read data, registered.
- `con_dout`  in  8  programming result (0x00 ok, 0xFF verify fail).
- `con_dout_en`  in  1  result valid pulse.
- `ack_dout`  out  8  status code to the control path.
- `ack_en`  out  1  status valid pulse.
- `drop_cnt`  out  16  frames discarded because the block was busy; saturating.

## Operation
- Frame format: byte0 type, bytes1–2 `pack_num` (MSB first), bytes3–4 `pack_cnt` (MSB first), bytes5–260 payload.
- Payload bytes pair MSB first into 16-bit words, written to buffer address 0..127 in order.
- End of frame is the first cycle with `din_en` low after it was high.
- The byte counter is 9 bits and saturates at 511.
- States:
  - IDLE: `din_en` high → HDR.
  - HDR: the first 5 bytes are captured into shadow registers.
  - PAYLOAD: buffer writes.
  - CHECK: one cycle, validates the frame.
  - HANDOFF: `wr_ram_end` high; on `wr_ram_ack` → WAIT_RESULT.
  - WAIT_RESULT: on `con_dout_en` → REPORT.
  - REPORT: one-cycle `ack_en`, then IDLE.
- CHECK rules, first failure wins; each failure gives one `ack_en` pulse with the code shown, then IDLE, with no handoff:
  - Length ≠ `FRAME_LEN` → 0xE1.
  - Type not 0x01/0x02 → 0xE2.
  - `pack_cnt`==0, or `pack_cnt`>`pack_num`, or `pack_cnt` not equal to (last accepted+1) and not 1 → 0xE3.
  - `pack_cnt`==1 with a type differing from the current session is accepted; it restarts the session.
- On pass:
  - Shadow header copies into `pack_cnt` / `pack_num`.
  - `update_flag` / `reconfig_flag` are set from type; mutually exclusive; held until the next `pack_cnt`==1 frame.
  - If `pack_cnt`==1, `config_reset` pulses in the first HANDOFF cycle, coincident with `wr_ram_end` rising.
- REPORT: `ack_dout` = `con_dout` (0x00 or 0xFF). On 0xFF the expected sequence resets, so the next frame must carry `pack_cnt`==1.
- After the last page (`pack_cnt`==`pack_num`) reports 0x00, the expected sequence resets to 1.
- WAIT_RESULT timeout: a counter reaching `RESULT_TIMEOUT` → `ack_dout`=0xE5, expected sequence resets, IDLE.
- Busy drop:
  - Applies to a frame starting (`din_en` rising) in HANDOFF/WAIT_RESULT/REPORT.
  - The frame is ignored entirely; the buffer is not written.
  - `drop_cnt`+1 at frame end; one `ack_en` with 0xE4, issued after REPORT completes (queued, depth 1).
- Buffer read: `wr_ram_rdata` <= mem[`wr_ram_raddr`] on `clk` when `wr_ram_en`, otherwise holds.
- Buffer contents are stable from CHECK until IDLE.

## Timing
- Reset (`rst` low, async): all outputs 0; `drop_cnt`=0; state IDLE; expected `pack_cnt`=1; buffer contents undefined.
- Byte k of a frame (k≥5) is written to mem[(k−5)>>1] in the cycle after the odd byte of each pair arrives.
- Frame end → CHECK in the next cycle → HANDOFF (`wr_ram_end` high) in the cycle after that.
- `wr_ram_end` falls the cycle after `wr_ram_ack` is sampled high. If `wr_ram_ack` arrives in the first HANDOFF cycle, `wr_ram_end` is high for exactly 1 cycle.
- `con_dout_en` → `ack_en` 1 cycle later.
- `con_dout_en` outside WAIT_RESULT is ignored.
- `rst` asserted mid-frame or mid-handoff: immediate return to the reset state; a partial frame is discarded.
- `din_en` glitch high in CHECK/REPORT: treated as a busy drop.

## Test plan
- Valid type 0x01 frame, `pack_num`=2, `pack_cnt`=1, payload bytes 0x00..0xFF:
  - `config_reset` and `update_flag` high with `wr_ram_end` rising.
  - mem[0]=0x0001, mem[127]=0xFEFF.
  - `wr_ram_ack` → `wr_ram_end` low next cycle.
  - `con_dout`=0x00 → `ack_dout`=0x00.
- Frame of 260 bytes → `ack_dout`=0xE1, no `wr_ram_end`.
- Type 0x07 frame → 0xE2.
- `pack_cnt`=3 after accepted 1 → 0xE3.
- Second frame sent during WAIT_RESULT → `drop_cnt`=1, 0xE4 after the first result's 0x00; buffer unchanged (read mem[5] before/after).
- `con_dout`=0xFF, then a frame with `pack_cnt`=2 → 0xFF reported then 0xE3.
- `rst` low during PAYLOAD → outputs 0; a following valid `pack_cnt`=1 frame is accepted.
- No `con_dout_en` with `RESULT_TIMEOUT`=100 → 0xE5 101 cycles after the ack.
